alien_laser_ctrl: RTL and testbench

Owns the three alien laser slots: launches lasers from the shooter alien, moves them down the screen once per frame and retires them on a hit or at the screen bottom. Sits directly upstream of the barrier stage: drives the packed 3×10-bit alien laser X/Y buses it consumes, and takes back its per-laser hit flags to retire lasers.

---
 rtl/alien_laser_ctrl.sv | 168 ++++++++++++++++
 tb/tb_alien_laser_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_laser_ctrl.sv
// alien_laser_ctrl: owns the three alien laser slots. Launches lasers from
// the shooter alien, steps them down once per frame, retires them on a hit
// or past the screen bottom.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   mode              1 = game running, 0 = clear slots and reload timer
//   frame_tick        one-cycle pulse per video frame
//   shooter_x/y       position of the alien chosen to fire
//   shooter_valid     shooter_x/y meaningful (an alien is alive)
//   alienLaserHit     barrier hit flags, bits [2:0] = slots 0..2
//   playerHit         spaceship hit flags, one per slot
//   alienLaserXcoord  packed X, slot n at [10n+9:10n]
//   alienLaserYcoord  packed Y, slot n at [10n+9:10n]
//   laserActive       per-slot active flag
//   fire_ack          pulses on the cycle a launch becomes visible
module alien_laser_ctrl #(
    parameter logic [9:0] SCREEN_BOTTOM = 10'd480,
    parameter logic [9:0] LASER_STEP    = 10'd4,
    parameter logic [9:0] SPAWN_OFFSET  = 10'd16,
    parameter logic [7:0] FIRE_INTERVAL = 8'd45
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        frame_tick,
    input  logic [9:0]  shooter_x,
    input  logic [9:0]  shooter_y,
    input  logic        shooter_valid,
    input  logic [11:0] alienLaserHit,
    input  logic [2:0]  playerHit,
    output logic [29:0] alienLaserXcoord,
    output logic [29:0] alienLaserYcoord,
    output logic [2:0]  laserActive,
    output logic        fire_ack
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } slot_state_e;

    slot_state_e state_q [3];
    slot_state_e state_d [3];
    logic [9:0]  x_q [3];
    logic [9:0]  x_d [3];
    logic [9:0]  y_q [3];
    logic [9:0]  y_d [3];
    logic [7:0]  timer_q;
    logic [7:0]  timer_d;
    logic        fire_ack_q;
    logic        fire_ack_d;

    logic [2:0]  free;
    logic [2:0]  launch_sel;
    logic        launch;
    logic [2:0]  hit;
    logic [10:0] y_next [3];

    // Upper barrier hit bits belong to other shooters' lasers.
    logic unused_hit_bits;
    assign unused_hit_bits = ^alienLaserHit[11:3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 3; n++) begin
                state_q[n] <= IDLE;
                x_q[n]     <= 10'd0;
                y_q[n]     <= 10'd0;
            end
            timer_q    <= FIRE_INTERVAL;
            fire_ack_q <= 1'b0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                state_q[n] <= state_d[n];
                x_q[n]     <= x_d[n];
                y_q[n]     <= y_d[n];
            end
            timer_q    <= timer_d;
            fire_ack_q <= fire_ack_d;
        end
    end

    always_comb begin
        free       = 3'b000;
        launch_sel = 3'b000;
        hit        = alienLaserHit[2:0] | playerHit;
        for (int n = 0; n < 3; n++) begin
            free[n] = (state_q[n] == IDLE);
        end

        // Only slots idle at the start of the cycle may take a launch,
        // so a slot freed this cycle waits one cycle.
        if (free[0]) begin
            launch_sel = 3'b001;
        end else if (free[1]) begin
            launch_sel = 3'b010;
        end else if (free[2]) begin
            launch_sel = 3'b100;
        end

        launch = mode && (timer_q == 8'd0) && shooter_valid && (|free);

        for (int n = 0; n < 3; n++) begin
            state_d[n] = state_q[n];
            x_d[n]     = x_q[n];
            y_d[n]     = y_q[n];
            // Compare in 11 bits so a step near the bottom cannot wrap.
            y_next[n]  = {1'b0, y_q[n]} + {1'b0, LASER_STEP};

            if (!mode) begin
                state_d[n] = IDLE;
                x_d[n]     = 10'd0;
                y_d[n]     = 10'd0;
            end else begin
                unique case (state_q[n])
                    ACTIVE: begin
                        if (hit[n]) begin
                            state_d[n] = IDLE;
                            x_d[n]     = 10'd0;
                            y_d[n]     = 10'd0;
                        end else if (frame_tick) begin
                            if (y_next[n] > {1'b0, SCREEN_BOTTOM}) begin
                                state_d[n] = IDLE;
                                x_d[n]     = 10'd0;
                                y_d[n]     = 10'd0;
                            end else begin
                                y_d[n] = y_next[n][9:0];
                            end
                        end
                    end
                    IDLE: begin
                        if (launch && launch_sel[n]) begin
                            state_d[n] = ACTIVE;
                            x_d[n]     = shooter_x;
                            y_d[n]     = shooter_y + SPAWN_OFFSET;
                        end
                    end
                    default: begin
                        state_d[n] = IDLE;
                    end
                endcase
            end
        end

        timer_d    = timer_q;
        fire_ack_d = 1'b0;
        if (!mode) begin
            timer_d = FIRE_INTERVAL;
        end else if (launch) begin
            timer_d    = FIRE_INTERVAL;
            fire_ack_d = 1'b1;
        end else if (frame_tick && (timer_q != 8'd0)) begin
            timer_d = timer_q - 8'd1;
        end
    end

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            alienLaserXcoord[10*n +: 10] = x_q[n];
            alienLaserYcoord[10*n +: 10] = y_q[n];
            laserActive[n]               = (state_q[n] == ACTIVE);
        end
    end

    assign fire_ack = fire_ack_q;

endmodule

// File: tb/tb_alien_laser_ctrl.sv
// tb_alien_laser_ctrl: randomized + directed stimulus against a behavioural
// slot model; a monitor compares DUT outputs against queued expectations.
module tb_alien_laser_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        frame_tick;
    logic [9:0]  shooter_x;
    logic [9:0]  shooter_y;
    logic        shooter_valid;
    logic [11:0] alienLaserHit;
    logic [2:0]  playerHit;

    logic [29:0] x0, y0, x1, y1;
    logic [2:0]  a0, a1;
    logic        k0, k1;

    always #5 clk = ~clk;

    alien_laser_ctrl dut0 (
        .clk(clk), .rst(rst), .mode(mode), .frame_tick(frame_tick),
        .shooter_x(shooter_x), .shooter_y(shooter_y),
        .shooter_valid(shooter_valid), .alienLaserHit(alienLaserHit),
        .playerHit(playerHit), .alienLaserXcoord(x0),
        .alienLaserYcoord(y0), .laserActive(a0), .fire_ack(k0)
    );

    // Short fire interval so three lasers can be alive with the timer at 0.
    alien_laser_ctrl #(.FIRE_INTERVAL(8'd3)) dut1 (
        .clk(clk), .rst(rst), .mode(mode), .frame_tick(frame_tick),
        .shooter_x(shooter_x), .shooter_y(shooter_y),
        .shooter_valid(shooter_valid), .alienLaserHit(alienLaserHit),
        .playerHit(playerHit), .alienLaserXcoord(x1),
        .alienLaserYcoord(y1), .laserActive(a1), .fire_ack(k1)
    );

    typedef struct packed {
        logic [2:0]  act;
        logic [29:0] x;
        logic [29:0] y;
        logic        ack;
    } exp_t;

    exp_t sbq0[$];
    exp_t sbq1[$];

    int total = 0;
    int bad   = 0;

    bit m_act [2][3];
    int m_x   [2][3];
    int m_y   [2][3];
    int m_tmr [2];
    bit m_ack [2];
    int m_fi  [2] = '{45, 3};

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 3; n++) begin
                m_act[i][n] = 0;
                m_x[i][n]   = 0;
                m_y[i][n]   = 0;
            end
            m_tmr[i] = m_fi[i];
            m_ack[i] = 0;
        end
    endfunction

    function automatic void model_step(input bit md, input bit ft,
                                       input int sx, input int sy,
                                       input bit sv, input int hits);
        for (int i = 0; i < 2; i++) begin
            int  slot;
            bit  go;
            m_ack[i] = 0;
            if (!md) begin
                for (int n = 0; n < 3; n++) begin
                    m_act[i][n] = 0;
                    m_x[i][n]   = 0;
                    m_y[i][n]   = 0;
                end
                m_tmr[i] = m_fi[i];
            end else begin
                slot = -1;
                for (int n = 2; n >= 0; n--) if (!m_act[i][n]) slot = n;
                go = (m_tmr[i] == 0) && sv && (slot >= 0);
                for (int n = 0; n < 3; n++) begin
                    if (m_act[i][n]) begin
                        if (((hits >> n) & 1) != 0 ||
                            (ft && m_y[i][n] + 4 > 480)) begin
                            m_act[i][n] = 0;
                            m_x[i][n]   = 0;
                            m_y[i][n]   = 0;
                        end else if (ft) begin
                            m_y[i][n] = m_y[i][n] + 4;
                        end
                    end
                end
                if (go) begin
                    m_act[i][slot] = 1;
                    m_x[i][slot]   = sx;
                    m_y[i][slot]   = (sy + 16) % 1024;
                    m_tmr[i]       = m_fi[i];
                    m_ack[i]       = 1;
                end else if (ft && m_tmr[i] > 0) begin
                    m_tmr[i] = m_tmr[i] - 1;
                end
            end
        end
    endfunction

    function automatic exp_t model_out(input int i);
        exp_t e;
        e = '0;
        for (int n = 0; n < 3; n++) begin
            e.act[n]       = m_act[i][n];
            e.x[10*n +: 10] = 10'(m_x[i][n]);
            e.y[10*n +: 10] = 10'(m_y[i][n]);
        end
        e.ack = m_ack[i];
        return e;
    endfunction

    task automatic push_exp();
        sbq0.push_back(model_out(0));
        sbq1.push_back(model_out(1));
    endtask

    task automatic cyc(input bit md, input bit ft, input int sx,
                       input int sy, input bit sv,
                       input logic [11:0] alh, input logic [2:0] ph);
        @(negedge clk);
        mode          = md;
        frame_tick    = ft;
        shooter_x     = 10'(sx);
        shooter_y     = 10'(sy);
        shooter_valid = sv;
        alienLaserHit = alh;
        playerHit     = ph;
        model_step(md, ft, sx, sy, sv, int'(alh[2:0] | ph));
        push_exp();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        mode          = 1'b0;
        frame_tick    = 1'b0;
        shooter_valid = 1'b0;
        alienLaserHit = 12'h0;
        playerHit     = 3'b0;
        #1;
        chk("rst_act", {29'd0, a0, a1}, 32'd0);
        chk("rst_x", x0 | x1, 32'd0);
        chk("rst_y", y0 | y1, 32'd0);
        chk("rst_ack", {30'd0, k0, k1}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        model_step(0, 0, 0, 0, 0, 0);
        push_exp();
    endtask

    // Run frame ticks with the shooter invalid until instance i may fire.
    task automatic drain(input int i);
        int guard;
        guard = 0;
        while (m_tmr[i] != 0 && guard < 300) begin
            cyc(1, 1, 0, 0, 0, 12'h0, 3'b0);
            guard++;
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq0.size() > 0) begin
            e = sbq0.pop_front();
            chk("act0", {29'd0, a0}, {29'd0, e.act});
            chk("x0", {2'd0, x0}, {2'd0, e.x});
            chk("y0", {2'd0, y0}, {2'd0, e.y});
            chk("ack0", {31'd0, k0}, {31'd0, e.ack});
        end
        if (sbq1.size() > 0) begin
            e = sbq1.pop_front();
            chk("act1", {29'd0, a1}, {29'd0, e.act});
            chk("x1", {2'd0, x1}, {2'd0, e.x});
            chk("y1", {2'd0, y1}, {2'd0, e.y});
            chk("ack1", {31'd0, k1}, {31'd0, e.ack});
        end
    end

    initial begin
        rst           = 1'b1;
        mode          = 1'b0;
        frame_tick    = 1'b0;
        shooter_x     = 10'd0;
        shooter_y     = 10'd0;
        shooter_valid = 1'b0;
        alienLaserHit = 12'h0;
        playerHit     = 3'b0;
        model_reset();
        do_reset();

        // First launch: (100,50) -> Y=66.
        drain(0);
        cyc(1, 0, 100, 50, 1, 12'h0, 3'b0);
        repeat (5) cyc(1, 1, 0, 0, 0, 12'h0, 3'b0);

        // Reset mid-flight, then launch only after 45 ticks.
        do_reset();
        repeat (47) cyc(1, 1, 7, 20, 1, 12'h0, 3'b0);

        // Move and retire at the bottom edge.
        cyc(0, 0, 0, 0, 0, 12'h0, 3'b0);
        drain(0);
        cyc(1, 0, 200, 456, 1, 12'h0, 3'b0);
        repeat (3) begin
            cyc(1, 1, 0, 0, 0, 12'h0, 3'b0);
            cyc(1, 0, 0, 0, 0, 12'h0, 3'b0);
        end

        // Hit beats move; upper barrier bits ignored.
        drain(0);
        cyc(1, 0, 10, 100, 1, 12'h0, 3'b0);
        drain(0);
        cyc(1, 0, 20, 284, 1, 12'h0, 3'b0);
        cyc(1, 1, 0, 0, 0, 12'h002, 3'b0);
        repeat (4) cyc(1, 0, 0, 0, 0, 12'hFF8, 3'b0);
        cyc(1, 1, 0, 0, 0, 12'h5A8, 3'b0);

        // Full slots on the short-interval instance.
        cyc(0, 0, 0, 0, 0, 12'h0, 3'b0);
        drain(1);
        cyc(1, 0, 30, 40, 1, 12'h0, 3'b0);
        drain(1);
        cyc(1, 0, 60, 40, 1, 12'h0, 3'b0);
        drain(1);
        cyc(1, 0, 90, 40, 1, 12'h0, 3'b0);
        drain(1);
        repeat (3) cyc(1, 0, 5, 5, 1, 12'h0, 3'b0);
        cyc(1, 0, 5, 5, 1, 12'h0, 3'b010);
        cyc(1, 0, 77, 5, 1, 12'h0, 3'b0);
        cyc(1, 0, 5, 5, 1, 12'h0, 3'b0);

        // Mode drop, then shooter invalid at timer 0.
        cyc(0, 0, 0, 0, 1, 12'h0, 3'b0);
        drain(0);
        repeat (5) cyc(1, 0, 300, 10, 0, 12'h0, 3'b0);
        cyc(1, 0, 300, 10, 1, 12'h0, 3'b0);

        // Randomized traffic.
        for (int r = 0; r < 3000; r++) begin
            bit          md, ft, sv;
            logic [11:0] alh;
            logic [2:0]  ph;
            if (r == 1500) do_reset();
            md  = ($urandom % 100) != 0;
            ft  = ($urandom % 3) == 0;
            sv  = ($urandom % 4) != 0;
            alh = (($urandom % 8) == 0) ? 12'($urandom) : 12'h0;
            ph  = (($urandom % 10) == 0) ? 3'($urandom) : 3'b0;
            cyc(md, ft, int'($urandom % 640), int'($urandom % 400),
                sv, alh, ph);
        end

        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", 32'(sbq0.size() + sbq1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
